// File: rtl/strobe_multiplier.sv
// Strobe multiplier: measures input strobe spacing, emits 2^MULT_LOG2 strobes per interval.
// Optional lock-loss on period jitter: define STROBE_MULT_TOLERANCE_EN.
module strobe_multiplier #(
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned MULT_LOG2    = 2,
  parameter int unsigned TOL          = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_stb,
  output logic                    o_stb,
  output logic                    o_locked,
  output logic [PERIOD_WIDTH-1:0] o_period
);

  localparam int unsigned PW = PERIOD_WIDTH;
  localparam int unsigned M  = 1 << MULT_LOG2;

  localparam logic [PW:0] M_W   = (PW+1)'(M);
  localparam logic [PW:0] TOL_W = (PW+1)'(TOL);

  localparam logic [PW-1:0] CNT_LAST =
    {{(PW-1){1'b1}}, 1'b0};

`ifdef STROBE_MULT_TOLERANCE_EN
  localparam bit TOL_EN = 1'b1;
`else
  localparam bit TOL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW:0]   acc_q, acc_d;
  logic [PW-1:0] period_q, period_d;
  logic          stb_q, stb_d;
  logic          lock_q, lock_d;

  logic [PW:0] p_w;
  logic [PW:0] per_w;
  logic [PW:0] sum_w;
  logic [PW:0] diff_w;
  logic        p_ok;
  logic        tol_bad;
  logic        timeout;

  always_comb begin
    p_w     = {1'b0, cnt_q} + 1'b1;
    per_w   = {1'b0, period_q};
    sum_w   = acc_q + M_W;
    diff_w  = (p_w > per_w) ? (p_w - per_w)
                            : (per_w - p_w);
    p_ok    = (p_w >= M_W);
    tol_bad = TOL_EN && (diff_w > TOL_W);
    timeout = (cnt_q == CNT_LAST);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    period_d = period_q;
    stb_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_stb) begin
          state_d = MEASURE;
          cnt_d   = '0;
        end
      end
      MEASURE, LOCKED: begin
        if (i_stb) begin
          cnt_d = '0;
          if (!p_ok ||
              (state_q == LOCKED && tol_bad)) begin
            state_d = MEASURE;
          end else begin
            // New interval restarts the phase at zero.
            state_d  = LOCKED;
            period_d = p_w[PW-1:0];
            stb_d    = 1'b1;
            acc_d    = (p_w > M_W) ? M_W : '0;
          end
        end else if (timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == LOCKED) begin
            stb_d = (acc_q < M_W);
            acc_d = (sum_w >= per_w) ? (sum_w - per_w)
                                     : sum_w;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    lock_d = (state_d == LOCKED);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      period_q <= '0;
      stb_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      period_q <= period_d;
      stb_q    <= stb_d;
      lock_q   <= lock_d;
    end
  end

  assign o_stb    = stb_q;
  assign o_locked = lock_q;
  assign o_period = period_q;

endmodule

// File: tb/tb_strobe_multiplier.sv
// Bench for strobe_multiplier: directed scenarios plus random intervals
// against an arithmetic phase model (strobe when (j*M) mod P < M).
module tb_strobe_multiplier;

  localparam int PW   = 8;
  localparam int ML   = 2;
  localparam int TOLV = 2;
  localparam int M    = 1 << ML;
  localparam int MAXC = (1 << PW) - 1;

`ifdef STROBE_MULT_TOLERANCE_EN
  localparam bit TOL_ON = 1'b1;
`else
  localparam bit TOL_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          stb_i = 1'b0;
  logic          o_stb;
  logic          o_locked;
  logic [PW-1:0] o_period;

  always #5 clk = ~clk;

  strobe_multiplier #(
    .PERIOD_WIDTH(PW),
    .MULT_LOG2   (ML),
    .TOL         (TOLV)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst_i),
    .i_stb   (stb_i),
    .o_stb   (o_stb),
    .o_locked(o_locked),
    .o_period(o_period)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: mode 0 idle, 1 measuring, 2 locked.
  int mode  = 0;
  int since = 0;
  int per   = 0;
  int p;
  int d;
  bit e_stb  = 1'b0;
  bit e_lock = 1'b0;

  always @(posedge clk) begin
    if (rst_i) begin
      mode   = 0;
      since  = 0;
      per    = 0;
      e_stb  = 1'b0;
      e_lock = 1'b0;
    end else begin
      e_stb = 1'b0;
      if (mode == 0) begin
        if (stb_i) begin
          mode  = 1;
          since = 0;
        end
      end else if (stb_i) begin
        p     = since + 1;
        since = 0;
        d     = (p > per) ? p - per : per - p;
        if (p < M) begin
          mode = 1;
        end else if (mode == 2 && TOL_ON && d > TOLV) begin
          mode = 1;
        end else begin
          mode  = 2;
          per   = p;
          e_stb = 1'b1;
        end
      end else if (since == MAXC - 1) begin
        mode  = 0;
        since = 0;
      end else begin
        since++;
        if (mode == 2)
          e_stb = ((since * M) % per) < M;
      end
      e_lock = (mode == 2);
    end
  end

  task automatic chk(input string tag,
                     input int unsigned act,
                     input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               tag, act, exp, $time);
    end
  endtask

  task automatic tick(input logic s, input logic r);
    stb_i = s;
    rst_i = r;
    @(posedge clk);
    #1;
    chk("o_stb", o_stb, e_stb);
    chk("o_locked", o_locked, e_lock);
    chk("o_period", o_period, per);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n - 1; i++)
      tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  int r;
  int last_p = 16;

  initial begin
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) gap(16);
    for (int i = 0; i < 5; i++) gap(10);
    for (int i = 0; i < 5; i++) gap(4);
    gap(3);
    gap(3);
    for (int i = 0; i < 3; i++) gap(20);
    gap(300);
    gap(20);
    gap(20);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) gap(16);
    gap(18);
    gap(19);
    gap(19);
    gap(MAXC);
    gap(MAXC);
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
      end else if (r < 15) begin
        gap($urandom_range(1, M - 1));
      end else if (r < 20) begin
        gap($urandom_range(MAXC - 3, MAXC + 40));
      end else if (r < 60) begin
        gap(last_p + $urandom_range(0, 6) - 3 > M ?
            last_p + $urandom_range(0, 6) - 3 : M);
      end else begin
        last_p = $urandom_range(M, 40);
        gap(last_p);
      end
    end
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
